uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Byte-level command framer and executor on the user side of the `uart` block. It pops bytes from the UART receive FIFO and assembles fixed 5-byte frames. It validates each frame's checksum, issues a single register write or read strobe on a simple register bus, and pushes a one-byte response into the UART transmit FIFO. It is the host-link control path between the serial port and on-chip control registers.

## Interface
- `SYNC`, 8'hAA, frame start byte
- `ACK`, 8'h06, response to a valid write
- `NAK`, 8'h15, response to a bad checksum or unknown command
- `TO_W`, 16, width of the inter-byte timeout counter
- `TIMEOUT`, 16'd50000, idle cycles allowed between bytes of one frame

Ports:
- `clk` in 1: single clock for all logic
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block
- `rx_empty` in 1: RX FIFO empty; `r_data` is valid whenever this is 0
- `r_data` in 8: RX FIFO head byte (first-word fall-through)
- `rd_uart` out 1: pop strobe to RX FIFO, one cycle per byte
- `tx_full` in 1: TX FIFO full
- `wr_uart` out 1: push strobe to TX FIFO
- `w_data` out 8: byte pushed when `wr_uart`=1
- `reg_addr` out 8: register address, held from EXEC until the next frame's ADDR byte
- `reg_wdata` out 8: register write data
- `reg_we` out 1: one-cycle write strobe
- `reg_re` out 1: one-cycle read strobe
- `reg_rdata` in 8: read data, valid the cycle after `reg_re`
- `frame_err` out 1: one-cycle pulse on a NAKed or timed-out frame
- `busy` out 1: high in every state except IDLE

## Operation
- Frame format: `SYNC`, CMD, ADDR, DATA, CHK, with CHK = CMD^ADDR^DATA.
- CMD 8'h57 ('W') is a write; CMD 8'h52 ('R') is a read. Any other CMD is unknown.
- States:
  - IDLE, CMD, ADDR, DATA, CHK: byte collection.
  - EXEC, RDWAIT, RESP: execution and response.
- Byte consumption: in any collection state, when `rx_empty`=0, assert `rd_uart`, capture `r_data`, and advance. At most one pop per cycle.
- IDLE: a popped byte equal to `SYNC` moves to CMD; any other byte is discarded and the state stays IDLE.
- No resync mid-frame: a `SYNC` value received in CMD, ADDR, DATA or CHK is treated as ordinary data.
- CHK moves to EXEC. A checksum is computed as a running XOR.
- EXEC:
  - Checksum bad or CMD unknown: response = `NAK`, pulse `frame_err`, no register strobe, go to RESP.
  - Write: pulse `reg_we`, response = `ACK`, go to RESP.
  - Read: pulse `reg_re`, go to RDWAIT.
- RDWAIT: capture `reg_rdata` as the response byte, go to RESP.
- RESP: hold until `tx_full`=0. In that cycle assert `wr_uart` for exactly one cycle with `w_data` equal to the response byte, then go to IDLE.
- `rd_uart` is 0 in EXEC, RDWAIT and RESP. The RX FIFO absorbs backpressure.

## Timing
- Reset values:
  - Outputs: `rd_uart`, `wr_uart`, `reg_we`, `reg_re`, `frame_err` and `busy` are 0; `w_data`, `reg_addr` and `reg_wdata` are 8'h00.
  - Internal: state = IDLE, timeout counter = 0.
- Reset mid-frame abandons the frame with no strobe and no response.
- Latency, with cycle N = the cycle CHK is popped:
  - EXEC strobe at N+1.
  - Write/NAK: `wr_uart` at N+2 at the earliest.
  - Read: `reg_rdata` sampled at N+2, `wr_uart` at N+3 at the earliest.
- Minimum frame time: 5 pop cycles when the FIFO is pre-filled.
- `rd_uart` and `wr_uart` are never high in the same cycle.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - In CMD, ADDR, DATA and CHK, a `TO_W`-bit counter increments each cycle `rx_empty`=1 and clears on every pop.
  - When the counter reaches `TIMEOUT`, pulse `frame_err`, clear the counter and return to IDLE. No response is sent.
  - The counter is held at 0 in the other states.
- `UART_CMD_TIMEOUT_EN` undefined: no counter logic; a partial frame waits indefinitely.

## Test plan
- Write: RX = AA 57 10 3C 7B -> `reg_we` one cycle with `reg_addr`=10, `reg_wdata`=3C; TX push 06; `frame_err`=0.
- Read: RX = AA 52 10 00 42, `reg_rdata`=5A -> `reg_re` one cycle with `reg_addr`=10; TX push 5A the cycle after capture.
- Errors:
  - RX = AA 57 10 3C 00 (bad CHK) -> TX 15, `frame_err` pulse, no `reg_we`.
  - RX = AA 41 00 00 41 (unknown CMD) -> TX 15, `frame_err` pulse, no strobe.
- Garbage and backpressure: RX = 00 FF 13 then the write frame -> 3 bytes discarded in IDLE, then normal ACK. Hold `tx_full`=1 for 20 cycles in RESP -> `wr_uart` stays 0, fires once when released.
- Timeout (macro on, `TIMEOUT`=100): RX = AA 57 then idle -> `frame_err` pulse 100 cycles after the last pop, no TX. A following valid frame is ACKed. With the macro off, the block stays in ADDR.
- Reset: assert `reset`=0 after the ADDR byte -> all outputs reset next edge, no strobe or TX. A subsequent frame is processed normally.

Source files
------------

// File: rtl/uart_cmd_parser.sv
module uart_cmd_parser #(
  parameter logic [7:0]      SYNC    = 8'hAA,
  parameter logic [7:0]      ACK     = 8'h06,
  parameter logic [7:0]      NAK     = 8'h15,
  parameter int unsigned     TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, CHK, EXEC, RDWAIT, RESP} state_t;

  state_t     state;
  logic [7:0] cmd_byte;
  logic [7:0] chk_acc;
  logic       err_q;
  logic       collecting;
  logic       in_frame;
  logic       pop;

  always_comb begin
    in_frame   = (state == CMD) || (state == ADDR) || (state == DATA) || (state == CHK);
    collecting = in_frame || (state == IDLE);
    pop        = reset && collecting && !rx_empty;
    rd_uart    = pop;
    wr_uart    = reset && (state == RESP) && !tx_full;
    busy       = (state != IDLE);
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  always_comb begin
    to_hit    = reset && in_frame && rx_empty && (to_cnt == TO_LAST);
    frame_err = err_q | to_hit;
  end
`else
  always_comb begin
    frame_err = err_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_byte  <= '0;
      chk_acc   <= '0;
      w_data    <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: if (pop && (r_data == SYNC)) state <= CMD;
        CMD: if (pop) begin
          cmd_byte <= r_data;
          chk_acc  <= r_data;
          state    <= ADDR;
        end
        ADDR: if (pop) begin
          reg_addr <= r_data;
          chk_acc  <= chk_acc ^ r_data;
          state    <= DATA;
        end
        DATA: if (pop) begin
          reg_wdata <= r_data;
          chk_acc   <= chk_acc ^ r_data;
          state     <= CHK;
        end
        // Verdict registered on the CHK pop so the strobe appears during EXEC.
        CHK: if (pop) begin
          state <= EXEC;
          if ((chk_acc != r_data) || ((cmd_byte != CMD_WR) && (cmd_byte != CMD_RD))) begin
            w_data <= NAK;
            err_q  <= 1'b1;
          end else if (cmd_byte == CMD_WR) begin
            w_data <= ACK;
            reg_we <= 1'b1;
          end else begin
            reg_re <= 1'b1;
          end
        end
        EXEC:    state <= reg_re ? RDWAIT : RESP;
        RDWAIT: begin
          w_data <= reg_rdata;
          state  <= RESP;
        end
        RESP:    if (!tx_full) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef UART_CMD_TIMEOUT_EN
      if (!in_frame || pop) begin
        to_cnt <= '0;
      end else if (to_hit) begin
        to_cnt <= '0;
        state  <= IDLE;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       tx_full = 1'b0;
  logic [7:0] reg_rdata = 8'h00;
  logic       rd_uart, wr_uart, reg_we, reg_re, frame_err, busy;
  logic [7:0] w_data, reg_addr, reg_wdata;

  always #5 clk = ~clk;

  uart_cmd_parser #(.TIMEOUT(16'd100)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .frame_err(frame_err), .busy(busy)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO = 100;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] rxq [$];

  int         fill = 0;
  logic [7:0] fr [5];
  bit         pending = 0;
  int         exec_cyc = -1, resp_cyc = -1, verdict = 0, last_pop = 0, chk_pop_cyc = 0;
  logic [7:0] resp_byte = 8'h00, exp_addr = 8'h00, exp_wdata = 8'h00;

  int         tx_cnt = 0, we_cnt = 0, re_cnt = 0, err_cnt = 0, pop_cnt = 0;
  int         last_wr_cyc = 0, last_err_cyc = 0, last_dut_pop = 0;
  logic [7:0] last_tx = 8'h00;

  function automatic logic [7:0] mem_val(input logic [7:0] a);
    return a ^ 8'h4A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    fill = 0; pending = 0; exp_addr = 8'h00; exp_wdata = 8'h00;
  endtask

  task automatic step();
    logic e_rd, e_wr, e_we, e_re, e_err, e_busy, to_fire;
    logic [7:0] b;
    e_rd    = !pending && !rx_empty;
    to_fire = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
    to_fire = (fill > 0) && !pending && rx_empty && (cyc == last_pop + TO);
`endif
    e_wr   = pending && (cyc >= resp_cyc) && !tx_full;
    e_we   = pending && (cyc == exec_cyc) && (verdict == 1);
    e_re   = pending && (cyc == exec_cyc) && (verdict == 2);
    e_err  = (pending && (cyc == exec_cyc) && (verdict == 0)) || to_fire;
    e_busy = (fill > 0) || pending;
    check("rd_uart", rd_uart, e_rd);
    check("wr_uart", wr_uart, e_wr);
    check("reg_we", reg_we, e_we);
    check("reg_re", reg_re, e_re);
    check("frame_err", frame_err, e_err);
    check("busy", busy, e_busy);
    check("reg_addr", reg_addr, exp_addr);
    check("reg_wdata", reg_wdata, exp_wdata);
    if (e_wr) check("w_data", w_data, resp_byte);

    if (rd_uart) begin pop_cnt++; last_dut_pop = cyc; end
    if (wr_uart) begin tx_cnt++; last_tx = w_data; last_wr_cyc = cyc; end
    if (reg_we) we_cnt++;
    if (reg_re) re_cnt++;
    if (frame_err) begin err_cnt++; last_err_cyc = cyc; end

    if (e_wr) begin pending = 0; fill = 0; end
    if (to_fire) fill = 0;
    if (e_rd) begin
      b = r_data;
      last_pop = cyc;
      if (fill == 0) begin
        if (b == 8'hAA) fill = 1;
      end else begin
        fr[fill] = b;
        if (fill == 2) exp_addr = b;
        if (fill == 3) exp_wdata = b;
        fill++;
        if (fill == 5) begin
          pending = 1; exec_cyc = cyc + 1; chk_pop_cyc = cyc;
          if (((fr[1] ^ fr[2] ^ fr[3]) != fr[4]) || ((fr[1] != 8'h57) && (fr[1] != 8'h52))) begin
            verdict = 0; resp_byte = 8'h15; resp_cyc = cyc + 2;
          end else if (fr[1] == 8'h57) begin
            verdict = 1; resp_byte = 8'h06; resp_cyc = cyc + 2;
          end else begin
            verdict = 2; resp_byte = mem_val(fr[2]); resp_cyc = cyc + 3;
          end
        end
      end
    end
  endtask

  initial begin : monitor
    logic       pop_now, re_now;
    logic [7:0] re_addr;
    pop_now = 1'b0; re_now = 1'b0; re_addr = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pop_now && rxq.size() > 0) rxq.delete(0);
      if (re_now) reg_rdata = mem_val(re_addr);
      #1;
      rx_empty = (rxq.size() == 0);
      r_data   = rx_empty ? 8'h00 : rxq[0];
      @(negedge clk);
      pop_now = rd_uart; re_now = reg_re; re_addr = reg_addr;
      if (reset) step();
      else model_reset();
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push5(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) rxq.push_back(f[i*8 +: 8]);
  endtask

  task automatic wait_tx(input int n, input string name);
    for (int i = 0; i < 300 && tx_cnt == n; i++) tick();
    checks++;
    if (tx_cnt == n) begin
      failures++;
      $display("FAIL %s no TX push within budget got=%0d exp=%0d", name, tx_cnt, n + 1);
    end
    idle(2);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rxq.delete();
    tick();
    check("rst_rd_uart", rd_uart, 0);
    check("rst_wr_uart", wr_uart, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_re", reg_re, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_w_data", w_data, 8'h00);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin : main
    int t0, w0, r0, e0, p0;
    idle(2);
    do_reset();

    t0 = tx_cnt; w0 = we_cnt; e0 = err_cnt; p0 = pop_cnt;
    push5(40'hAA_57_10_3C_7B);
    wait_tx(t0, "write");
    check("wr_tx_byte", last_tx, 8'h06);
    check("wr_we_pulses", we_cnt - w0, 1);
    check("wr_no_err", err_cnt - e0, 0);
    check("wr_latency", last_wr_cyc - chk_pop_cyc, 2);
    check("wr_pops", pop_cnt - p0, 5);
    check("wr_addr_held", reg_addr, 8'h10);
    check("wr_wdata", reg_wdata, 8'h3C);

    t0 = tx_cnt; r0 = re_cnt;
    push5(40'hAA_52_10_00_42);
    wait_tx(t0, "read");
    check("rd_tx_byte", last_tx, 8'h5A);
    check("rd_re_pulses", re_cnt - r0, 1);
    check("rd_latency", last_wr_cyc - chk_pop_cyc, 3);

    t0 = tx_cnt; w0 = we_cnt; e0 = err_cnt;
    push5(40'hAA_57_10_3C_00);
    wait_tx(t0, "badchk");
    check("badchk_tx", last_tx, 8'h15);
    check("badchk_err", err_cnt - e0, 1);
    check("badchk_no_we", we_cnt - w0, 0);

    t0 = tx_cnt; w0 = we_cnt; r0 = re_cnt; e0 = err_cnt;
    push5(40'hAA_41_00_00_41);
    wait_tx(t0, "unkcmd");
    check("unk_tx", last_tx, 8'h15);
    check("unk_err", err_cnt - e0, 1);
    check("unk_no_strobe", (we_cnt - w0) + (re_cnt - r0), 0);

    t0 = tx_cnt; p0 = pop_cnt;
    rxq.push_back(8'h00); rxq.push_back(8'hFF); rxq.push_back(8'h13);
    push5(40'hAA_57_10_3C_7B);
    wait_tx(t0, "garbage");
    check("garb_tx", last_tx, 8'h06);
    check("garb_pops", pop_cnt - p0, 8);

    t0 = tx_cnt;
    tx_full = 1'b1;
    push5(40'hAA_57_22_01_74);
    idle(27);
    check("bp_held", tx_cnt - t0, 0);
    check("bp_busy", busy, 1);
    tx_full = 1'b0;
    wait_tx(t0, "backpressure");
    check("bp_tx", last_tx, 8'h06);
    check("bp_once", tx_cnt - t0, 1);

    t0 = tx_cnt; e0 = err_cnt;
    rxq.push_back(8'hAA); rxq.push_back(8'h57);
    idle(130);
    check("to_no_tx", tx_cnt - t0, 0);
`ifdef UART_CMD_TIMEOUT_EN
    check("to_err", err_cnt - e0, 1);
    check("to_delay", last_err_cyc - last_dut_pop, 100);
    check("to_idle", busy, 0);
    t0 = tx_cnt;
    push5(40'hAA_57_10_3C_7B);
    wait_tx(t0, "after_timeout");
    check("to_next_ack", last_tx, 8'h06);
`else
    check("to_stuck_busy", busy, 1);
    check("to_no_err", err_cnt - e0, 0);
    do_reset();
`endif

    t0 = tx_cnt; w0 = we_cnt;
    rxq.push_back(8'hAA); rxq.push_back(8'h57); rxq.push_back(8'h10);
    idle(6);
    do_reset();
    check("mid_rst_no_tx", tx_cnt - t0, 0);
    check("mid_rst_no_we", we_cnt - w0, 0);
    push5(40'hAA_57_10_3C_7B);
    wait_tx(t0, "after_reset");
    check("post_rst_tx", last_tx, 8'h06);
    check("post_rst_we", we_cnt - w0, 1);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish got=running exp=done");
    $fatal(1, "watchdog");
  end

endmodule
